// File: rtl/wb_port_arbiter.sv
// Write-port arbiter for the register bank: loads versus ALU results,
// with a small FIFO holding ALU results that lose to a load.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_valid,
    output logic              ram_ready,
    input  logic [ADDR_W-1:0] ram_rd,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              mux_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {EMPTY, PART, FULL} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] fifo_rd_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              mux_sel_q, mux_sel_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              push, pop, grant, gnt_sel;
    logic [ADDR_W-1:0] gnt_rd;
    logic [DATA_W-1:0] gnt_data;
    logic              ready;

    assign ready     = (state_q != FULL);
    assign ram_ready = ready;
    assign alu_ready = ready;

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        grant    = 1'b0;
        gnt_sel  = 1'b0;
        gnt_rd   = fifo_rd_q[rd_ptr_q];
        gnt_data = fifo_data_q[rd_ptr_q];
        if (state_q == FULL) begin
            pop   = 1'b1;
            grant = 1'b1;
        end else if (ram_valid) begin
            grant    = 1'b1;
            gnt_sel  = 1'b1;
            gnt_rd   = ram_rd;
            gnt_data = ram_data;
            push     = alu_valid;
        end else if (state_q == PART) begin
            pop   = 1'b1;
            grant = 1'b1;
            push  = alu_valid;
        end else if (alu_valid) begin
            grant    = 1'b1;
            gnt_rd   = alu_rd;
            gnt_data = alu_data;
        end
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == (PTR_W+1)'(DEPTH)) begin
            state_d = FULL;
        end else begin
            state_d = PART;
        end
    end

    // Register 0 is hardwired: consume the transfer but suppress the strobe.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mux_sel_d = mux_sel_q;
        if (grant) begin
            wr_en_d   = (gnt_rd != '0);
            wr_addr_d = gnt_rd;
            wr_data_d = (gnt_rd != '0) ? gnt_data : '0;
            mux_sel_d = gnt_sel;
        end
        stall_cnt_d = stall_cnt_q;
        if (ram_valid && !ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mux_sel_q   <= 1'b0;
            stall_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mux_sel_q   <= mux_sel_d;
            stall_cnt_q <= stall_cnt_d;
            if (push) begin
                fifo_rd_q[wr_ptr_q]   <= alu_rd;
                fifo_data_q[wr_ptr_q] <= alu_data;
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign mux_sel   = mux_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model
// compared every cycle, plus hand-computed spot checks.
module tb_wb_port_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ram_valid = 1'b0;
    logic              ram_ready;
    logic [ADDR_W-1:0] ram_rd = '0;
    logic [DATA_W-1:0] ram_data = '0;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mux_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  stall_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ram_valid(ram_valid), .ram_ready(ram_ready),
        .ram_rd(ram_rd), .ram_data(ram_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mux_sel(mux_sel), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending ALU results, outputs
    // recomputed from the grant rules each cycle.
    logic [ADDR_W+DATA_W-1:0] q[$];
    logic              e_en = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_data = '0;
    logic              e_sel = 1'b0;
    logic [CNT_W-1:0]  e_stall = '0;

    always @(posedge clk or negedge rst_n) begin
        logic g;
        logic g_sel;
        logic [ADDR_W-1:0] g_rd;
        logic [DATA_W-1:0] g_dat;
        if (!rst_n) begin
            q.delete();
            e_en = 1'b0; e_addr = '0; e_data = '0; e_sel = 1'b0; e_stall = '0;
        end else begin
            g = 1'b0; g_sel = 1'b0; g_rd = '0; g_dat = '0;
            if (q.size() == DEPTH) begin
                if (ram_valid && e_stall != {CNT_W{1'b1}}) e_stall = e_stall + 1;
                {g_rd, g_dat} = q.pop_front();
                g = 1'b1;
            end else if (ram_valid) begin
                g = 1'b1; g_sel = 1'b1; g_rd = ram_rd; g_dat = ram_data;
                if (alu_valid) q.push_back({alu_rd, alu_data});
            end else if (q.size() != 0) begin
                {g_rd, g_dat} = q.pop_front();
                g = 1'b1;
                if (alu_valid) q.push_back({alu_rd, alu_data});
            end else if (alu_valid) begin
                g = 1'b1; g_rd = alu_rd; g_dat = alu_data;
            end
            if (g) begin
                e_en = (g_rd != 0);
                e_addr = g_rd;
                e_data = (g_rd != 0) ? g_dat : '0;
                e_sel = g_sel;
            end else begin
                e_en = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("wr_en", wr_en, e_en);
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
            chk("mux_sel", mux_sel, e_sel);
            chk("stall_cnt", stall_cnt, e_stall);
            chk("ram_ready", ram_ready, q.size() != DEPTH);
            chk("alu_ready", alu_ready, q.size() != DEPTH);
        end
    end

    task automatic cyc(input logic rv, input logic [ADDR_W-1:0] rr,
                       input logic [DATA_W-1:0] rd,
                       input logic av, input logic [ADDR_W-1:0] ar,
                       input logic [DATA_W-1:0] ad);
        @(negedge clk);
        #1;
        ram_valid = rv; ram_rd = rr; ram_data = rd;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        // 1: reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checking = 1'b1;
        idle();
        chk("t1_wr_en", wr_en, 1'b0);
        chk("t1_stall", stall_cnt, 8'd0);
        chk("t1_ram_ready", ram_ready, 1'b1);
        chk("t1_alu_ready", alu_ready, 1'b1);

        // 2: ALU bypass
        cyc(1'b0, '0, '0, 1'b1, 5'd3, 32'h5);
        chk("t2_wr_en", wr_en, 1'b1);
        chk("t2_wr_addr", wr_addr, 5'd3);
        chk("t2_wr_data", wr_data, 32'h5);
        chk("t2_mux_sel", mux_sel, 1'b0);
        chk("t2_alu_ready", alu_ready, 1'b1);
        idle();

        // 3: collision, load first then buffered ALU
        cyc(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd5, 32'h12);
        chk("t3_addr_a", wr_addr, 5'd4);
        chk("t3_data_a", wr_data, 32'hFFFF_FFFF);
        chk("t3_sel_a", mux_sel, 1'b1);
        idle();
        chk("t3_addr_b", wr_addr, 5'd5);
        chk("t3_data_b", wr_data, 32'h12);
        chk("t3_sel_b", mux_sel, 1'b0);
        idle();
        chk("t3_idle_en", wr_en, 1'b0);

        // 4: fill FIFO, stall a load
        cyc(1'b1, 5'd8, 32'h80, 1'b1, 5'd6, 32'h6);
        cyc(1'b1, 5'd9, 32'h90, 1'b1, 5'd7, 32'h7);
        chk("t4_full_ram_ready", ram_ready, 1'b0);
        chk("t4_full_alu_ready", alu_ready, 1'b0);
        cyc(1'b1, 5'd10, 32'h100, 1'b0, '0, '0);
        chk("t4_drain6_addr", wr_addr, 5'd6);
        chk("t4_drain6_sel", mux_sel, 1'b0);
        chk("t4_stall1", stall_cnt, 8'd1);
        cyc(1'b1, 5'd10, 32'h100, 1'b0, '0, '0);
        chk("t4_load10", wr_addr, 5'd10);
        cyc(1'b1, 5'd11, 32'h110, 1'b0, '0, '0);
        chk("t4_load11", wr_data, 32'h110);
        idle();
        chk("t4_drain7_addr", wr_addr, 5'd7);
        chk("t4_drain7_data", wr_data, 32'h7);
        idle();
        chk("t4_done_en", wr_en, 1'b0);
        chk("t4_done_stall", stall_cnt, 8'd1);

        // 5: register 0
        cyc(1'b0, '0, '0, 1'b1, 5'd0, 32'hAB);
        chk("t5_wr_en", wr_en, 1'b0);
        chk("t5_wr_addr", wr_addr, 5'd0);
        chk("t5_wr_data", wr_data, 32'h0);
        chk("t5_alu_ready", alu_ready, 1'b1);
        idle();

        // stall counter saturation
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h66);
        end
        chk("sat_stall", stall_cnt, 8'hFF);
        repeat (3) idle();
        chk("sat_hold", stall_cnt, 8'hFF);

        // 6: mid-operation asynchronous reset
        cyc(1'b1, 5'd12, 32'hC, 1'b1, 5'd6, 32'h6);
        cyc(1'b1, 5'd13, 32'hD, 1'b1, 5'd7, 32'h7);
        ram_valid = 1'b0; alu_valid = 1'b0;
        chk("t6_full", ram_ready, 1'b0);
        chk("t6_pre_en", wr_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_en", wr_en, 1'b0);
        chk("t6_rst_addr", wr_addr, 5'd0);
        chk("t6_rst_data", wr_data, 32'h0);
        chk("t6_rst_stall", stall_cnt, 8'd0);
        chk("t6_rst_ready", ram_ready, 1'b1);
        #1 rst_n = 1'b1;
        idle();
        chk("t6_no_r6", wr_en, 1'b0);
        idle();
        chk("t6_no_r7", wr_en, 1'b0);
        chk("t6_addr_zero", wr_addr, 5'd0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
